arm_multicycle_ctrl: RTL and testbench
======================================

Name: arm_multicycle_ctrl

Overview:
- Multicycle sequencer for the ARM-subset datapath: a memory port shared by instruction and data, a single ALU reused for PC+4, and a register file.
- Decodes the held instruction fields and walks a Moore FSM, one state per cycle.
- Drives the same control set as the single-cycle controller (RegSrc, ImmSrc, ALUSrc*, ALUControl, MemWrite, RegWrite, PC write), plus IRWrite, AdrSrc and ResultSrc.
- Owns the NZCV flags register and the condition check.

Parameters:
- NUM_STATES, 10, FSM state count; sets the state encoding width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Cond  in  4  Instr[31:28], from the instruction register
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from the ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALU result register as memory address
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = const 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  bit0 = (Op==10), bit1 = (Op==01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- RegWrite  out  1  register file write enable
- Flags  out  4  registered NZCV
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_instr  out  1  one-cycle pulse in DECODE when Op==11

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset state: state=FETCH, Flags=0000.
- Outputs while reset is high: PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_instr are forced to 0. All other outputs take their FETCH values.
- Reset mid-instruction: the instruction is abandoned and no further writes occur.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH with illegal_instr=1.
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH, with instr_done=1.
- Instruction latency: ADD-immediate 4 cycles, LDR 5, STR 4, B 3.
- Per-state control (unlisted signals are 0 / 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1 (ResultSrc=00).
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 -> ALUControl=00.
  - ALUOp=1, by Funct[4:1]: 0100 -> 00; 0010 -> 01; 0000 -> 10; 1100 -> 11; 1010 (CMP) -> 01 with NoWrite=1; any other value -> 00 with NoWrite=1.
- Condition check: CondEx is combinational from Cond and the registered Flags, using the ARM encodings 0000..1110. Cond=1111 gives CondEx=0.
- Gated writes:
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
  - PCWrite = NextPC | ((Branch | (RegW & Rd==15)) & CondEx).
- Flag update, at the clock edge leaving EXECR or EXECI, only when Funct[0]=1 (S bit) and CondEx=1:
  - NZ <- ALUFlags[3:2].
  - CV <- ALUFlags[1:0], only when ALUControl is 00 or 01.
  - Flags do not change in any other state.
- Cond, Op, Funct and Rd must be stable from DECODE until FETCH; the datapath IR guarantees this.

Decomposition:
- Package arm_ctrl_pkg:
  - state_t enum.
  - ALUControl localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR.
  - Op encodings: OP_DP, OP_MEM, OP_BR.
  - ResultSrc and ALUSrcB encodings.
  - Cond code constants.
- Sub-module cond_check: Cond, Flags -> CondEx. Purely combinational; reused by the single-cycle controller.

Test Plan:
- Reset held 2 cycles, then released -> state=FETCH, Flags=0000, IRWrite=0 during reset and IRWrite=1 on the first cycle after release.
- ADD R1,R2,#5 (E2821005) -> FETCH, DECODE, EXECI, ALUWB. ALUControl=00 and ALUSrcB=01 in EXECI; RegWrite=1 and instr_done=1 in ALUWB. Total 4 cycles.
- LDR R3,[R1,#4] (E5913004) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. Then STR (E5813008) -> MemWrite=1 in MEMWR only, RegWrite never asserted.
- SUBS R0,R0,#1 (E2500001) with ALUFlags=0100 in EXECI -> Flags=0100 from the next cycle. Then:
  - BNE (1A000002) -> PCWrite=0 in BRANCH.
  - BEQ (0A000002) -> PCWrite=1 in BRANCH.
- ADDNE R1,R2,#5 (12821005) with Z=1 -> RegWrite=0 in ALUWB; Flags unchanged; instr_done=1.
- reset asserted during MEMRD of an LDR -> next state is FETCH; no RegWrite or MemWrite pulse occurs. Op=11 instruction -> illegal_instr=1 in DECODE, FETCH on the next cycle.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset controllers: FSM states, ALU operations,
// instruction classes, mux selects and condition codes.
package arm_ctrl_pkg;

    localparam int STATE_COUNT = 10;
    localparam int STATE_W     = $clog2(STATE_COUNT);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against an NZCV flag set; purely combinational
// so both the single-cycle and multicycle controllers can share it.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic neg, zero, carry, overflow, ge;

    assign {neg, zero, carry, overflow} = Flags;
    assign ge = (neg == overflow);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = zero;
            COND_NE: CondEx = ~zero;
            COND_CS: CondEx = carry;
            COND_CC: CondEx = ~carry;
            COND_MI: CondEx = neg;
            COND_PL: CondEx = ~neg;
            COND_VS: CondEx = overflow;
            COND_VC: CondEx = ~overflow;
            COND_HI: CondEx = carry & ~zero;
            COND_LS: CondEx = ~(carry & ~zero);
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~zero & ge;
            COND_LE: CondEx = ~(~zero & ge);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle sequencer for the ARM-subset datapath: Moore FSM, ALU decode,
// NZCV flag register and condition-gated write enables.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int NUM_STATES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] Flags,
    output logic       instr_done,
    output logic       illegal_instr
);

    localparam int STATE_BITS = $clog2(NUM_STATES);

    logic [STATE_BITS-1:0] state_q;
    state_t state, next_state, out_state;
    logic [3:0] flags_q;
    logic cond_ex, flag_en;
    logic next_pc, branch, reg_w, mem_w, ir_w, alu_op, done_raw, illegal_raw;
    logic [1:0] dp_ctl;
    logic dp_no_write, no_write;

    assign state = state_t'(state_q);

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // Flags only move on the edge that leaves an execute state of an S-suffixed, passing instruction
    assign flag_en = ((state == S_EXECR) || (state == S_EXECI)) && Funct[0] && cond_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= next_state;
            if (flag_en) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (!ALUControl[1]) begin
                    flags_q[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXECR,
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // While reset is high the outputs show FETCH, with every write strobe suppressed
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        next_pc     = 1'b0;
        branch      = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        ir_w        = 1'b0;
        alu_op      = 1'b0;
        done_raw    = 1'b0;
        illegal_raw = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RD2;
        case (out_state)
            S_FETCH: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                illegal_raw = (Op == 2'b11);
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                done_raw  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                mem_w    = 1'b1;
                done_raw = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                reg_w    = 1'b1;
                done_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
                done_raw  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            next_pc = 1'b0;
            ir_w    = 1'b0;
        end
    end

    // Unknown data-processing commands execute as ADD but never write back
    always_comb begin
        dp_ctl      = ALU_ADD;
        dp_no_write = 1'b0;
        case (Funct[4:1])
            4'b0100: dp_ctl = ALU_ADD;
            4'b0010: dp_ctl = ALU_SUB;
            4'b0000: dp_ctl = ALU_AND;
            4'b1100: dp_ctl = ALU_ORR;
            4'b1010: begin
                dp_ctl      = ALU_SUB;
                dp_no_write = 1'b1;
            end
            default: dp_no_write = 1'b1;
        endcase
    end

    assign no_write      = (Op == OP_DP) && dp_no_write;
    assign ALUControl    = alu_op ? dp_ctl : ALU_ADD;
    assign ImmSrc        = Op;
    assign RegSrc        = {(Op == OP_MEM), (Op == OP_BR)};
    assign IRWrite       = ir_w;
    assign RegWrite      = reg_w & cond_ex & ~no_write;
    assign MemWrite      = mem_w & cond_ex;
    assign PCWrite       = next_pc | ((branch | (reg_w & (Rd == 4'd15))) & cond_ex);
    assign Flags         = flags_q;
    assign instr_done    = done_raw;
    assign illegal_instr = illegal_raw;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Cycle-accurate checks of the multicycle controller: a table of per-cycle
// vectors run through a scoreboard, plus instruction-latency sequences.
module tb_arm_multicycle_ctrl;
    import arm_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] alu_control;
        logic       reg_write;
        logic [3:0] flags;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic [3:0]  af;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] ADDI   = 32'hE2821005;
    localparam logic [31:0] ADDPC  = 32'hE282F005;
    localparam logic [31:0] ORRR   = 32'hE1821003;
    localparam logic [31:0] LDR    = 32'hE5913004;
    localparam logic [31:0] STR    = 32'hE5813008;
    localparam logic [31:0] SUBS   = 32'hE2500001;
    localparam logic [31:0] BNE    = 32'h1A000002;
    localparam logic [31:0] BEQ    = 32'h0A000002;
    localparam logic [31:0] ADDNE  = 32'h12821005;
    localparam logic [31:0] SUBSNE = 32'h12500001;
    localparam logic [31:0] CMPI   = 32'hE3500000;
    localparam logic [31:0] ANDS   = 32'hE2100001;
    localparam logic [31:0] ILL    = 32'hEC000000;
    localparam logic [31:0] BAL    = 32'hEA000002;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = '0, Rd = '0, ALUFlags = '0;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, instr_done, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags;

    outs_t act;
    outs_t exp_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;

    arm_multicycle_ctrl #(.NUM_STATES(10)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .Flags(Flags), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegSrc, ALUControl, RegWrite, Flags, instr_done, illegal_instr};

    // Per-state control values straight from the state table, unconditioned writes asserted
    function automatic outs_t st(input state_t s, input logic [31:0] ins, input logic [3:0] fl);
        outs_t o = '0;
        case (s)
            S_FETCH:  begin o.pc_write = 1; o.ir_write = 1; o.result_src = 2'b10; o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_DECODE: begin o.result_src = 2'b10; o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_MEMADR: o.alu_src_b = 2'b01;
            S_MEMRD:  o.adr_src = 1;
            S_MEMWB:  begin o.result_src = 2'b01; o.reg_write = 1; o.done = 1; end
            S_MEMWR:  begin o.adr_src = 1; o.mem_write = 1; o.done = 1; end
            S_EXECR:  o.alu_src_b = 2'b00;
            S_EXECI:  o.alu_src_b = 2'b01;
            S_ALUWB:  begin o.reg_write = 1; o.done = 1; end
            S_BRANCH: begin o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pc_write = 1; o.done = 1; end
            default:  ;
        endcase
        o.imm_src = ins[27:26];
        o.reg_src = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
        o.flags   = fl;
        return o;
    endfunction

    function automatic outs_t rstv(input logic [31:0] ins, input logic [3:0] fl);
        outs_t o = st(S_FETCH, ins, fl);
        o.pc_write = 0;
        o.ir_write = 0;
        return o;
    endfunction

    function automatic outs_t alu(input outs_t o, input logic [1:0] a);
        outs_t r = o;
        r.alu_control = a;
        return r;
    endfunction

    function automatic outs_t rw(input outs_t o, input logic b);
        outs_t r = o;
        r.reg_write = b;
        return r;
    endfunction

    function automatic outs_t pw(input outs_t o, input logic b);
        outs_t r = o;
        r.pc_write = b;
        return r;
    endfunction

    function automatic outs_t il(input outs_t o);
        outs_t r = o;
        r.illegal = 1;
        return r;
    endfunction

    task automatic add(input logic r, input logic [31:0] ins, input logic [3:0] af, input outs_t e);
        vec_t v;
        v.rst = r; v.ins = ins; v.af = af; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic [3:0] af);
        reset    = r;
        Cond     = ins[31:28];
        Op       = ins[27:26];
        Funct    = ins[25:20];
        Rd       = ins[15:12];
        ALUFlags = af;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v.rst, v.ins, v.af);
        exp_q.push_back(v.exp);
    endtask

    task automatic checkOutput(input int idx);
        outs_t e;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL vec%0d scoreboard empty got=%h", idx, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("[TB] FAIL vec%0d outputs got=%h want=%h", idx, act, e);
            end
        end
    endtask

    task automatic measure(input logic [31:0] ins, input int want, input string name);
        int  n = 0;
        logic seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            drive(1'b0, ins, 4'hF);
            @(negedge clk);
            if (instr_done === 1'b1) begin
                seen = 1;
                n = c;
            end
        end
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("[TB] FAIL latency_%s got=%0d want=%0d (seen=%0d)", name, n, want, seen);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        drive(1'b1, 32'h0, 4'h0);
        @(posedge clk);

        add(1, ADDI, 4'hF, rstv(ADDI, 4'h0));
        add(1, ADDI, 4'hF, rstv(ADDI, 4'h0));
        add(0, ADDI, 4'hF, st(S_FETCH,  ADDI, 4'h0));
        add(0, ADDI, 4'hF, st(S_DECODE, ADDI, 4'h0));
        add(0, ADDI, 4'hF, st(S_EXECI,  ADDI, 4'h0));
        add(0, ADDI, 4'hF, st(S_ALUWB,  ADDI, 4'h0));
        add(0, ADDPC, 4'hF, st(S_FETCH,  ADDPC, 4'h0));
        add(0, ADDPC, 4'hF, st(S_DECODE, ADDPC, 4'h0));
        add(0, ADDPC, 4'hF, st(S_EXECI,  ADDPC, 4'h0));
        add(0, ADDPC, 4'hF, pw(st(S_ALUWB, ADDPC, 4'h0), 1));
        add(0, ORRR, 4'hF, st(S_FETCH,  ORRR, 4'h0));
        add(0, ORRR, 4'hF, st(S_DECODE, ORRR, 4'h0));
        add(0, ORRR, 4'hF, alu(st(S_EXECR, ORRR, 4'h0), 2'b11));
        add(0, ORRR, 4'hF, st(S_ALUWB,  ORRR, 4'h0));
        add(0, LDR, 4'hF, st(S_FETCH,  LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_DECODE, LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMADR, LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMRD,  LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMWB,  LDR, 4'h0));
        add(0, STR, 4'hF, st(S_FETCH,  STR, 4'h0));
        add(0, STR, 4'hF, st(S_DECODE, STR, 4'h0));
        add(0, STR, 4'hF, st(S_MEMADR, STR, 4'h0));
        add(0, STR, 4'hF, st(S_MEMWR,  STR, 4'h0));
        add(0, SUBS, 4'hF, st(S_FETCH,  SUBS, 4'h0));
        add(0, SUBS, 4'hF, st(S_DECODE, SUBS, 4'h0));
        add(0, SUBS, 4'h4, alu(st(S_EXECI, SUBS, 4'h0), 2'b01));
        add(0, SUBS, 4'hF, st(S_ALUWB,  SUBS, 4'h4));
        add(0, BNE, 4'hF, st(S_FETCH,  BNE, 4'h4));
        add(0, BNE, 4'hF, st(S_DECODE, BNE, 4'h4));
        add(0, BNE, 4'hF, pw(st(S_BRANCH, BNE, 4'h4), 0));
        add(0, BEQ, 4'hF, st(S_FETCH,  BEQ, 4'h4));
        add(0, BEQ, 4'hF, st(S_DECODE, BEQ, 4'h4));
        add(0, BEQ, 4'hF, st(S_BRANCH, BEQ, 4'h4));
        add(0, ADDNE, 4'hF, st(S_FETCH,  ADDNE, 4'h4));
        add(0, ADDNE, 4'hF, st(S_DECODE, ADDNE, 4'h4));
        add(0, ADDNE, 4'hF, st(S_EXECI,  ADDNE, 4'h4));
        add(0, ADDNE, 4'hF, rw(st(S_ALUWB, ADDNE, 4'h4), 0));
        add(0, SUBSNE, 4'hF, st(S_FETCH,  SUBSNE, 4'h4));
        add(0, SUBSNE, 4'hF, st(S_DECODE, SUBSNE, 4'h4));
        add(0, SUBSNE, 4'h0, alu(st(S_EXECI, SUBSNE, 4'h4), 2'b01));
        add(0, SUBSNE, 4'hF, rw(st(S_ALUWB, SUBSNE, 4'h4), 0));
        add(0, CMPI, 4'hF, st(S_FETCH,  CMPI, 4'h4));
        add(0, CMPI, 4'hF, st(S_DECODE, CMPI, 4'h4));
        add(0, CMPI, 4'h6, alu(st(S_EXECI, CMPI, 4'h4), 2'b01));
        add(0, CMPI, 4'hF, rw(st(S_ALUWB, CMPI, 4'h6), 0));
        add(0, ANDS, 4'hF, st(S_FETCH,  ANDS, 4'h6));
        add(0, ANDS, 4'hF, st(S_DECODE, ANDS, 4'h6));
        add(0, ANDS, 4'h9, alu(st(S_EXECI, ANDS, 4'h6), 2'b10));
        add(0, ANDS, 4'hF, st(S_ALUWB,  ANDS, 4'hA));
        add(0, ILL, 4'hF, st(S_FETCH, ILL, 4'hA));
        add(0, ILL, 4'hF, il(st(S_DECODE, ILL, 4'hA)));
        add(0, LDR, 4'hF, st(S_FETCH,  LDR, 4'hA));
        add(0, LDR, 4'hF, st(S_DECODE, LDR, 4'hA));
        add(0, LDR, 4'hF, st(S_MEMADR, LDR, 4'hA));
        add(1, LDR, 4'hF, rstv(LDR, 4'hA));
        add(0, LDR, 4'hF, st(S_FETCH,  LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_DECODE, LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMADR, LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMRD,  LDR, 4'h0));
        add(0, LDR, 4'hF, st(S_MEMWB,  LDR, 4'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        measure(ADDI, 4, "addi");
        measure(LDR,  5, "ldr");
        measure(STR,  4, "str");
        measure(BAL,  3, "b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
